// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and helpers for the 7-segment scan decoder.
// Segment codes are common-cathode, active-high, bit0=a .. bit6=g.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [2:0] DIG_SEC_L = 3'd0;
  localparam logic [2:0] DIG_SEC_H = 3'd1;
  localparam logic [2:0] DIG_MIN_L = 3'd2;
  localparam logic [2:0] DIG_MIN_H = 3'd3;
  localparam logic [2:0] DIG_HR_L  = 3'd4;
  localparam logic [2:0] DIG_HR_H  = 3'd5;
  localparam logic [2:0] ERR_SEL   = 3'd7;

  // All digit selects released (active-low): a blank scan slot.
  localparam logic [5:0] SEL_NONE  = 6'h3F;
  // Marker stored for a segment pattern that is not a BCD digit.
  localparam logic [3:0] BCD_BAD   = 4'hF;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_HELD = 1'b1
  } filt_state_e;

  // Map a 7-segment pattern back to its BCD digit, BCD_BAD if not a digit.
  function automatic logic [3:0] seg2bcd(input logic [6:0] seg);
    logic [3:0] bcd;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: bcd = BCD_BAD;
    endcase
    return bcd;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_filter.sv
// seg_stable_filter: samples the scan bus, counts how long it has been
// unchanged and issues exactly one capture strobe per stable scan slot.
// With SEG_DP_CAPTURE_EN defined the decimal point is also passed out.
module seg_stable_filter
  import seg_pkg::*;
#(
  parameter int STABLE_CYC = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_sel,
  input  logic [7:0] i_seg,
  output logic [5:0] o_sel,
  output logic [6:0] o_seg,
`ifdef SEG_DP_CAPTURE_EN
  output logic       o_dp,
`endif
  output logic       o_strobe
);

  localparam int CW = $clog2(STABLE_CYC) + 1;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_TGT = CW'(STABLE_CYC - 1);

  logic [13:0]   r_cur;
  logic [CW-1:0] r_cnt;
  logic          r_strobe;
  filt_state_e   r_state;

  logic          w_change;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_strobe_nxt;
  filt_state_e   w_state_nxt;

  // Run-length counter and WAIT/HELD next-state; strobe on reaching the target.
  always_comb begin
    w_change     = ({i_sel, i_seg} != r_cur);
    w_cnt_nxt    = r_cnt;
    w_strobe_nxt = 1'b0;
    w_state_nxt  = r_state;
    if (w_change) begin
      w_cnt_nxt = {CW{1'b0}};
    end else if (r_cnt == CNT_MAX) begin
      w_cnt_nxt = r_cnt;
    end else begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
    case (r_state)
      ST_WAIT: begin
        if (!w_change && (w_cnt_nxt == CNT_TGT)) begin
          w_state_nxt  = ST_HELD;
          w_strobe_nxt = 1'b1;
        end else begin
          w_state_nxt  = ST_WAIT;
        end
      end
      ST_HELD: begin
        if (w_change) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_HELD;
        end
      end
      default: begin
        w_state_nxt = ST_WAIT;
      end
    endcase
  end

  // Sample register, counter, state and strobe; reset to a blank slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cur    <= {SEL_NONE, 8'h00};
      r_cnt    <= {CW{1'b0}};
      r_state  <= ST_WAIT;
      r_strobe <= 1'b0;
    end else begin
      r_cur    <= {i_sel, i_seg};
      r_cnt    <= w_cnt_nxt;
      r_state  <= w_state_nxt;
      r_strobe <= w_strobe_nxt;
    end
  end

  assign o_sel    = r_cur[13:8];
  assign o_seg    = r_cur[6:0];
`ifdef SEG_DP_CAPTURE_EN
  assign o_dp     = r_cur[7];
`endif
  assign o_strobe = r_strobe;

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: decodes a multiplexed common-cathode 7-segment scan back
// into a coherent six-digit hr/min/sec frame. Optional macro
// SEG_DP_CAPTURE_EN adds the dp_mask output carrying each digit's dp.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] sm_bit,
  input  logic [7:0] sm_seg,
  output logic [3:0] hr_h,
  output logic [3:0] hr_l,
  output logic [3:0] min_h,
  output logic [3:0] min_l,
  output logic [3:0] sec_h,
  output logic [3:0] sec_l,
  output logic       frame_valid,
  output logic       code_err,
`ifdef SEG_DP_CAPTURE_EN
  output logic [5:0] dp_mask,
`endif
  output logic [2:0] err_digit
);

  // Number of asserted (low) digit selects.
  function automatic logic [2:0] zero_count(input logic [5:0] sel);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) begin
      n = n + {2'b00, ~sel[i]};
    end
    return n;
  endfunction

  // Index of the lowest asserted select.
  function automatic logic [2:0] cold_index(input logic [5:0] sel);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (!sel[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  logic [5:0] w_cap_sel;
  logic [6:0] w_cap_seg;
  logic       w_cap_stb;

  logic [3:0] r_shadow [6];
  logic [3:0] r_dig    [6];
  logic [5:0] r_seen;
  logic       r_frame_valid;
  logic       r_code_err;
  logic [2:0] r_err_digit;

  logic [2:0] w_zeros;
  logic [2:0] w_idx;
  logic [3:0] w_bcd;
  logic       w_store;
  logic       w_err;
  logic [2:0] w_err_dig;
  logic       w_publish;
  logic [5:0] w_seen_nxt;

`ifdef SEG_DP_CAPTURE_EN
  logic       w_cap_dp;
  logic [5:0] r_dp_shadow;
  logic [5:0] r_dp_mask;
`endif

  seg_stable_filter #(
    .STABLE_CYC (STABLE_CYC)
  ) u_filter (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_sel    (sm_bit),
    .i_seg    (sm_seg),
    .o_sel    (w_cap_sel),
    .o_seg    (w_cap_seg),
`ifdef SEG_DP_CAPTURE_EN
    .o_dp     (w_cap_dp),
`endif
    .o_strobe (w_cap_stb)
  );

  // Classify a captured slot: blank, illegal select, or a digit to store.
  always_comb begin
    w_zeros   = zero_count(w_cap_sel);
    w_idx     = cold_index(w_cap_sel);
    w_bcd     = seg2bcd(w_cap_seg);
    w_store   = 1'b0;
    w_err     = 1'b0;
    w_err_dig = r_err_digit;
    if (!w_cap_stb) begin
      w_store = 1'b0;
    end else if (w_zeros == 3'd0) begin
      w_store = 1'b0;
    end else if (w_zeros == 3'd1) begin
      w_store = 1'b1;
      if (w_bcd == BCD_BAD) begin
        w_err     = 1'b1;
        w_err_dig = w_idx;
      end else begin
        w_err     = 1'b0;
      end
    end else begin
      w_err     = 1'b1;
      w_err_dig = ERR_SEL;
    end
  end

  // A full seen set publishes on the next edge; a capture on that same edge
  // starts the next frame instead of being lost.
  always_comb begin
    w_publish  = (r_seen == 6'h3F);
    w_seen_nxt = w_publish ? 6'h00 : r_seen;
    if (w_store) begin
      w_seen_nxt = w_seen_nxt | 6'(6'd1 << w_idx);
    end else begin
      w_seen_nxt = w_seen_nxt;
    end
  end

  // Shadow digit store, seen tracking and error reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        r_shadow[i] <= 4'h0;
      end
      r_seen      <= 6'h00;
      r_code_err  <= 1'b0;
      r_err_digit <= 3'd0;
    end else begin
      if (w_store) begin
        r_shadow[w_idx] <= w_bcd;
      end
      r_seen      <= w_seen_nxt;
      r_code_err  <= w_err;
      r_err_digit <= w_err_dig;
    end
  end

  // Atomic copy of all shadows to the outputs when a frame completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        r_dig[i] <= 4'h0;
      end
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= w_publish;
      if (w_publish) begin
        for (int i = 0; i < 6; i++) begin
          r_dig[i] <= r_shadow[i];
        end
      end
    end
  end

`ifdef SEG_DP_CAPTURE_EN
  // Decimal-point shadow and published mask, tracked alongside the digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dp_shadow <= 6'h00;
      r_dp_mask   <= 6'h00;
    end else begin
      if (w_store) begin
        r_dp_shadow[w_idx] <= w_cap_dp;
      end
      if (w_publish) begin
        r_dp_mask <= r_dp_shadow;
      end
    end
  end

  assign dp_mask = r_dp_mask;
`endif

  assign sec_l       = r_dig[DIG_SEC_L];
  assign sec_h       = r_dig[DIG_SEC_H];
  assign min_l       = r_dig[DIG_MIN_L];
  assign min_h       = r_dig[DIG_MIN_H];
  assign hr_l        = r_dig[DIG_HR_L];
  assign hr_h        = r_dig[DIG_HR_H];
  assign frame_valid = r_frame_valid;
  assign code_err    = r_code_err;
  assign err_digit   = r_err_digit;

endmodule
